dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder servicing load/store requests issued by the execute/memory pipeline stage over a valid/ready request channel and a valid/ready response channel. It holds a 16-word little-endian memory and performs byte-lane selection, store merging, sign/zero extension and misalignment detection. A programmable wait-state counter models slow memory so the pipeline's stall logic can be exercised. Only one transaction is in flight at a time.

## Interface
- WAIT_CYCLES, 1, wait states inserted between request acceptance and the memory access (0–15)
- ADDR_W, 6, byte-address width; word index is addr[5:2], giving 16 words

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal (funct3[1:0])
- req_uext  in  1  load zero-extend when 1, sign-extend when 0 (funct3[2])
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size access

## Operation
- FSM states are IDLE, WAIT and RESP. req_ready = (state == IDLE). rsp_valid = (state == RESP).
- In IDLE, when req_valid is high, the request fields are latched into internal registers. The counter loads WAIT_CYCLES − 1. The next state is WAIT, or RESP if WAIT_CYCLES == 0, with the access performed on that same edge.
- In WAIT, the counter decrements each cycle. On the edge where the counter is 0, the access is performed and the FSM moves to RESP.
- In RESP, rsp_rdata and rsp_err hold stable until rsp_valid && rsp_ready, then the FSM returns to IDLE. A new request is not accepted in the same cycle as the response handshake.
- The access uses only the latched request fields. Changes on the req_* inputs after acceptance are ignored.
- Error conditions:
  - size 11
  - half with addr[0] = 1
  - word with addr[1:0] ≠ 00
  
  On error: rsp_err = 1, rsp_rdata = 0, and memory is not modified.
- Loads:
  - byte: lane k = addr[1:0], data bits [8k+7:8k], extended from bit 7.
  - half: lane addr[1], bits [16·addr[1]+15:16·addr[1]], extended from bit 15.
  - word: returned unchanged.
- Stores write only the addressed lanes with the low bytes of req_wdata; the other lanes keep their values. rsp_rdata = 0.
- Address bits above ADDR_W do not exist. The word index is addr[5:2] with no wrap logic required.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, counter 0
  - req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0
  - all 16 memory words cleared to 0
- Reset mid-transaction aborts it. A store still in WAIT is never written. A store already in RESP has been committed but is then cleared by the memory reset.
- Latency: rsp_valid rises WAIT_CYCLES + 1 cycles after the acceptance edge. The default gives 2.
- Throughput: at most one transaction per WAIT_CYCLES + 2 cycles when rsp_ready is held high.
- Read-after-write: a load accepted after a store's response handshake returns the updated data.
- rsp_ready held low stalls in RESP indefinitely with outputs stable. req_ready stays 0 for the whole stall.
- All outputs are registered or decoded from registered state. There is no combinational path from req_* to rsp_*.

## Test plan
- Reset, then store word 0xDEADBEEF at 0x08, then load word at 0x08: rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid rising 2 cycles after each acceptance.
- Starting from that word, store byte 0x5A at 0x0B, then issue:
  - load word 0x08 → 0x5AADBEEF
  - lb 0x08 → 0xFFFFFFEF
  - lbu 0x08 → 0x000000EF
  - lh 0x0A → 0x00005AAD
- Misaligned accesses:
  - lh 0x05 → rsp_err = 1, rsp_rdata = 0
  - sw 0x06 of 0x12345678, then lw 0x04 → contents unchanged (0 after reset)
  - size 11 → rsp_err = 1
- Backpressure: hold rsp_ready low 5 cycles during a load response. rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a req_valid pulse is ignored. Release: handshake completes, and IDLE is reached the next cycle.
- WAIT_CYCLES = 0 and 3 builds: rsp_valid appears 1 and 4 cycles after acceptance respectively.
- Assert rst_n low while a store of 0xFFFFFFFF to 0x00 is in WAIT: rsp_valid = 0 and req_ready = 1 immediately, and a following lw 0x00 returns 0.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store data-memory responder with programmable wait states
`timescale 1ns/1ps
module dmem_responder #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_uext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                uext_q, uext_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         mem_q [16];
  logic [31:0]         mem_d [16];

  // With zero wait states the access happens on the acceptance edge, so it must
  // see the incoming request rather than the (not yet loaded) latched copy.
  logic                acc_write;
  logic [1:0]          acc_size;
  logic                acc_uext;
  logic [ADDR_W-1:0]   acc_addr;
  logic [31:0]         acc_wdata;
  logic [3:0]          acc_idx;
  logic [1:0]          acc_lane;
  logic [31:0]         acc_word;
  logic [31:0]         word_shr;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [31:0]         load_data;
  logic [31:0]         wdata_sh;
  logic [3:0]          byte_en;
  logic [31:0]         merged;
  logic                acc_err;
  logic                do_access;

  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = req_write;
      acc_size  = req_size;
      acc_uext  = req_uext;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_write = write_q;
      acc_size  = size_q;
      acc_uext  = uext_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_idx  = acc_addr[5:2];
    acc_lane = acc_addr[1:0];
    acc_word = mem_q[acc_idx];

    acc_err = (acc_size == 2'b11) ||
              ((acc_size == 2'b01) && acc_lane[0]) ||
              ((acc_size == 2'b10) && (acc_lane != 2'b00));

    word_shr = acc_word >> {acc_lane, 3'b000};
    byte_v   = word_shr[7:0];
    half_v   = acc_lane[1] ? acc_word[31:16] : acc_word[15:0];
    case (acc_size)
      2'b00:   load_data = {{24{~acc_uext & byte_v[7]}}, byte_v};
      2'b01:   load_data = {{16{~acc_uext & half_v[15]}}, half_v};
      2'b10:   load_data = acc_word;
      default: load_data = 32'h0;
    endcase

    wdata_sh = acc_wdata << {acc_lane, 3'b000};
    case (acc_size)
      2'b00:   byte_en = 4'b0001 << acc_lane;
      2'b01:   byte_en = 4'b0011 << acc_lane;
      default: byte_en = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = byte_en[i] ? wdata_sh[8*i +: 8] : acc_word[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    size_d    = size_q;
    uext_d    = uext_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    for (int i = 0; i < 16; i++) mem_d[i] = mem_q[i];

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uext_d  = req_uext;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = ST_RESP;
          end else begin
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? 32'h0 : load_data;
      if (acc_write && !acc_err) mem_d[acc_idx] = merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      uext_q  <= uext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      for (int i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder against a byte-array model
`timescale 1ns/1ps
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_uext;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v0, v3;
  logic        rr0, rr3, rv0, rv3, re0, re3;
  logic [31:0] rd0, rd3;

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [64];

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(1), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_uext(req_uext),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.WAIT_CYCLES(0), .ADDR_W(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rr0),
    .req_write(req_write), .req_size(req_size), .req_uext(req_uext),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv0),
    .rsp_ready(1'b1), .rsp_rdata(rd0), .rsp_err(re0));

  dmem_responder #(.WAIT_CYCLES(3), .ADDR_W(6)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rr3),
    .req_write(req_write), .req_size(req_size), .req_uext(req_uext),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv3),
    .rsp_ready(1'b1), .rsp_rdata(rd3), .rsp_err(re3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mb[i] = 8'h00;
  endtask

  // Memory as a flat little-endian byte array; access width in bytes drives alignment.
  task automatic model(input logic w, input logic [1:0] sz, input logic ue, input logic [5:0] a,
                       input logic [31:0] wd, output logic [31:0] r, output logic e);
    int n;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (sz == 2'd3) || ((int'(a) % n) != 0);
    r = 32'h0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | ({24'h0, mb[int'(a) + i]} << (8*i));
        if (!ue && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        r = v;
      end
    end
  endtask

  task automatic scramble();
    req_write = 1'($urandom);
    req_size  = 2'($urandom);
    req_uext  = 1'($urandom);
    req_addr  = 6'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic ue,
                     input logic [5:0] a, input logic [31:0] wd,
                     input logic use_lit, input logic [31:0] lit_d, input logic lit_e);
    logic [31:0] er;
    logic        ee;
    int          lat;
    model(w, sz, ue, a, wd, er, ee);
    @(negedge clk);
    chk({tag, ".req_ready"}, {31'h0, req_ready}, 32'd1);
    req_write = w; req_size = sz; req_uext = ue; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, 32'd2);
    chk({tag, ".rdata"}, rsp_rdata, er);
    chk({tag, ".err"}, {31'h0, rsp_err}, {31'h0, ee});
    if (use_lit) begin
      chk({tag, ".rdata_lit"}, rsp_rdata, lit_d);
      chk({tag, ".err_lit"}, {31'h0, rsp_err}, {31'h0, lit_e});
    end
    @(posedge clk); #1;
    chk({tag, ".back_idle"}, {30'h0, rsp_valid, req_ready}, 32'd1);
  endtask

  task automatic probe(input string tag, input int sel, input logic w, input logic [5:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_d, input int exp_lat);
    int lat;
    @(negedge clk);
    req_write = w; req_size = 2'd2; req_uext = 1'b0; req_addr = a; req_wdata = wd;
    if (sel == 0) v0 = 1'b1; else v3 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0; v3 = 1'b0;
    scramble();
    lat = 1;
    while (!((sel == 0) ? rv0 : rv3) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".rdata"}, (sel == 0) ? rd0 : rd3, exp_d);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] er, held;
    logic        ee;
    int          lat;

    req_valid = 1'b0; v0 = 1'b0; v3 = 1'b0; rsp_ready = 1'b1;
    scramble();
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.req_ready", {31'h0, req_ready}, 32'd1);
    chk("reset.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.rsp_err", {31'h0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    txn("sw08",  1'b1, 2'd2, 1'b0, 6'h08, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    txn("lw08",  1'b0, 2'd2, 1'b0, 6'h08, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
    txn("sb0b",  1'b1, 2'd0, 1'b0, 6'h0B, 32'h0000005A, 1'b1, 32'h0, 1'b0);
    txn("lw08b", 1'b0, 2'd2, 1'b0, 6'h08, 32'h0,        1'b1, 32'h5AADBEEF, 1'b0);
    txn("lb08",  1'b0, 2'd0, 1'b0, 6'h08, 32'h0,        1'b1, 32'hFFFFFFEF, 1'b0);
    txn("lbu08", 1'b0, 2'd0, 1'b1, 6'h08, 32'h0,        1'b1, 32'h000000EF, 1'b0);
    txn("lh0a",  1'b0, 2'd1, 1'b0, 6'h0A, 32'h0,        1'b1, 32'h00005AAD, 1'b0);
    txn("lh05",  1'b0, 2'd1, 1'b0, 6'h05, 32'h0,        1'b1, 32'h0, 1'b1);
    txn("sw06",  1'b1, 2'd2, 1'b0, 6'h06, 32'h12345678, 1'b1, 32'h0, 1'b1);
    txn("lw04",  1'b0, 2'd2, 1'b0, 6'h04, 32'h0,        1'b1, 32'h0, 1'b0);
    txn("sz11",  1'b0, 2'd3, 1'b0, 6'h08, 32'h0,        1'b1, 32'h0, 1'b1);

    // Backpressure: response held for 5 cycles with a stray store request in the middle.
    rsp_ready = 1'b0;
    model(1'b0, 2'd2, 1'b0, 6'h08, 32'h0, er, ee);
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd2; req_uext = 1'b0; req_addr = 6'h08;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.latency", lat, 32'd2);
    chk("bp.rdata", rsp_rdata, er);
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_write = 1'b1; req_size = 2'd2; req_addr = 6'h08; req_wdata = 32'h11111111;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("bp.hold_valid", {31'h0, rsp_valid}, 32'd1);
      chk("bp.hold_rdata", rsp_rdata, held);
      chk("bp.hold_ready", {31'h0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release", {30'h0, rsp_valid, req_ready}, 32'd1);
    txn("bp.after", 1'b0, 2'd2, 1'b0, 6'h08, 32'h0, 1'b1, 32'h5AADBEEF, 1'b0);

    for (int k = 0; k < 40; k++) begin
      txn("rand", 1'($urandom), 2'($urandom), 1'($urandom), 6'($urandom), $urandom,
          1'b0, 32'h0, 1'b0);
    end

    probe("wc0.sw", 0, 1'b1, 6'h10, 32'hCAFEF00D, 32'h0, 1);
    probe("wc0.lw", 0, 1'b0, 6'h10, 32'h0, 32'hCAFEF00D, 1);
    probe("wc3.sw", 3, 1'b1, 6'h10, 32'hCAFEF00D, 32'h0, 4);
    probe("wc3.lw", 3, 1'b0, 6'h10, 32'h0, 32'hCAFEF00D, 4);

    // Reset while a store sits in its wait state must drop it.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd2; req_uext = 1'b0; req_addr = 6'h00;
    req_wdata = 32'hFFFFFFFF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst.in_wait", {30'h0, rsp_valid, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst.req_ready", {31'h0, req_ready}, 32'd1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    txn("rst.lw00", 1'b0, 2'd2, 1'b0, 6'h00, 32'h0, 1'b1, 32'h0, 1'b0);
    txn("rst.lw08", 1'b0, 2'd2, 1'b0, 6'h08, 32'h0, 1'b1, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
